// File: rtl/l2_mem_responder_if.sv
// Shared L1-to-L2 request types and the bundled request/memory-port interface
// of the L2 word responder.
package xentry_pkg;
  typedef enum logic [1:0] {
    LOAD  = 2'b00,
    STORE = 2'b01
  } memory_operation_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ISSUE   = 2'b01,
    WAIT    = 2'b10,
    RESPOND = 2'b11
  } responder_state_e;
endpackage

interface l2_mem_responder_if #(
  parameter int XLEN = 32
);
  import xentry_pkg::*;

  logic [XLEN-1:0]   req_address;
  memory_operation_e req_type;
  logic              req_valid;
  logic [XLEN-1:0]   word_to_store;
  logic [XLEN-1:0]   fetched_word;
  logic              req_fulfilled;

  logic [XLEN-1:0]   mem_addr;
  logic              mem_we;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_valid;
  logic              mem_ready;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_rvalid;

  logic              timeout_error;

  modport slave (
    input  req_address, req_type, req_valid, word_to_store,
    input  mem_ready, mem_rdata, mem_rvalid,
    output fetched_word, req_fulfilled,
    output mem_addr, mem_we, mem_wdata, mem_valid, timeout_error
  );

  modport master (
    output req_address, req_type, req_valid, word_to_store,
    output mem_ready, mem_rdata, mem_rvalid,
    input  fetched_word, req_fulfilled,
    input  mem_addr, mem_we, mem_wdata, mem_valid, timeout_error
  );
endinterface

// File: rtl/l2_mem_responder.sv
// L2 word responder: takes one L1 request at a time, runs it against a
// ready/valid backing memory and returns the word with a one-cycle pulse.
module l2_mem_responder
  import xentry_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  l2_mem_responder_if.slave bus,
  output responder_state_e dbg_state
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] COUNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  // Handshakes: a request is taken when req_valid is seen in IDLE and is held by
  // the requester until the req_fulfilled pulse; a memory command transfers on a
  // cycle with mem_valid && mem_ready, and read data arrives on a mem_rvalid
  // pulse, which is only looked at in ISSUE and WAIT.

  responder_state_e state;
  logic [CW-1:0]    count;

  // Low address bits are dropped by word alignment.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.req_address[1:0];

  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      count             <= '0;
      bus.req_fulfilled <= 1'b0;
      bus.fetched_word  <= '0;
      bus.mem_valid     <= 1'b0;
      bus.mem_we        <= 1'b0;
      bus.mem_addr      <= '0;
      bus.mem_wdata     <= '0;
      bus.timeout_error <= 1'b0;
    end else begin
      bus.req_fulfilled <= 1'b0;
      case (state)
        IDLE: begin
          // The command registers double as the captured request.
          if (bus.req_valid) begin
            bus.mem_valid <= 1'b1;
            bus.mem_addr  <= {bus.req_address[XLEN-1:2], 2'b00};
            bus.mem_we    <= (bus.req_type == STORE);
            bus.mem_wdata <= (bus.req_type == STORE) ? bus.word_to_store : '0;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.mem_ready) begin
            bus.mem_valid <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            if (bus.mem_we) begin
              bus.fetched_word  <= '0;
              bus.req_fulfilled <= 1'b1;
              state             <= RESPOND;
            end else if (bus.mem_rvalid) begin
              bus.fetched_word  <= bus.mem_rdata;
              bus.req_fulfilled <= 1'b1;
              state             <= RESPOND;
            end else begin
              count <= '0;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          count <= count + CW'(1);
          // Data that shows up on the last allowed cycle still counts.
          if (bus.mem_rvalid) begin
            bus.fetched_word  <= bus.mem_rdata;
            bus.req_fulfilled <= 1'b1;
            state             <= RESPOND;
          end else if (count == COUNT_LAST) begin
            bus.fetched_word  <= '1;
            bus.timeout_error <= 1'b1;
            bus.req_fulfilled <= 1'b1;
            state             <= RESPOND;
          end
        end
        RESPOND: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_mem_responder.sv
// Bench for l2_mem_responder: directed vector table, hand-written reset and
// back-to-back sequences, then randomized transactions against a latency model.
module tb_l2_mem_responder;
  import xentry_pkg::*;

  localparam int TO = 4;

  typedef struct {
    logic [1:0]  typ;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          rdy;
    int          rv;
    logic [31:0] rdata;
    int          exp_lat;
    logic [31:0] exp_word;
  } vec_t;

  logic             clk;
  logic             rst_n;
  responder_state_e dbg_state;

  l2_mem_responder_if #(.XLEN(32)) bus ();

  l2_mem_responder #(.XLEN(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] exp_q[$];
  bit          exp_to  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Transaction-level reference: latency and returned word from the rules.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    bit is_store = (v.typ == 2'b01);
    bit timed_out = !is_store && (v.rv < 0 || v.rv > TO);
    r.exp_lat  = 2 + v.rdy + (is_store ? 0 : (timed_out ? TO : v.rv));
    r.exp_word = is_store ? 32'h0 : (timed_out ? 32'hFFFF_FFFF : v.rdata);
    return r;
  endfunction

  task automatic outputs_zero(input string name);
    chk(name, {bus.fetched_word ^ 32'h0, 27'h0, bus.req_fulfilled, bus.mem_valid, bus.mem_we,
               bus.timeout_error, 1'b0} | bus.mem_addr | bus.mem_wdata, 64'h0);
  endtask

  // Runs one request starting in an IDLE cycle; returns in the following IDLE cycle
  // with req_valid still asserted.
  task automatic run_txn(input vec_t v, input string tag);
    int          cmd_cycles = 0;
    bit          cmd_ok = 1'b1;
    bit          done = 1'b0;
    int          lat = -1;
    bit          is_store = (v.typ == 2'b01);
    logic [31:0] exp_addr = v.addr & 32'hFFFF_FFFC;
    logic [31:0] exp_wdata = is_store ? v.wdata : 32'h0;
    exp_q.push_back(v.exp_word);
    if (!is_store && (v.rv < 0 || v.rv > TO)) exp_to = 1'b1;
    bus.req_valid     = 1'b1;
    bus.req_type      = memory_operation_e'(v.typ);
    bus.req_address   = v.addr;
    bus.word_to_store = v.wdata;
    bus.mem_ready     = 1'b0;
    bus.mem_rvalid    = 1'b0;
    for (int c = 1; c <= v.exp_lat + 8 && !done; c++) begin
      @(posedge clk); #1;
      if (bus.mem_valid) begin
        cmd_cycles++;
        if (bus.mem_addr !== exp_addr || bus.mem_we !== is_store || bus.mem_wdata !== exp_wdata)
          cmd_ok = 1'b0;
      end
      if (bus.req_fulfilled) begin
        done = 1'b1;
        lat  = c;
        if (exp_q.size() == 0) chk({tag, " sb_empty"}, 32'h1, 32'h0);
        else chk({tag, " word"}, bus.fetched_word, exp_q.pop_front());
        chk({tag, " timeout_err"}, 32'(bus.timeout_error), 32'(exp_to));
      end
      bus.mem_ready  = (c == 1 + v.rdy);
      bus.mem_rvalid = (v.rv >= 0 && c == 1 + v.rdy + v.rv);
      bus.mem_rdata  = v.rdata;
    end
    if (!done) void'(exp_q.pop_front());
    chk({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    chk({tag, " cmd_cycles"}, 32'(cmd_cycles), 32'(v.rdy + 1));
    chk({tag, " cmd_fields"}, 32'(cmd_ok), 32'h1);
    @(posedge clk); #1;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    chk({tag, " pulse_width"}, 32'(bus.req_fulfilled), 32'h0);
  endtask

  vec_t tbl[8];
  vec_t rv_v;
  bit   idle_ok;

  initial begin
    tbl[0] = '{2'b01, 32'h0000_1006, 32'hDEAD_BEEF, 0, -1, 32'h0,         2, 32'h0};
    tbl[1] = '{2'b00, 32'h0000_0040, 32'h0,         3,  2, 32'h1234_5678, 7, 32'h1234_5678};
    tbl[2] = '{2'b00, 32'h0000_0080, 32'h0,         0,  0, 32'hA5A5_A5A5, 2, 32'hA5A5_A5A5};
    tbl[3] = '{2'b00, 32'h0000_0084, 32'h0,         1, -1, 32'h0,         7, 32'hFFFF_FFFF};
    tbl[4] = '{2'b00, 32'h0000_0088, 32'h0,         0,  4, 32'h600D_600D, 6, 32'h600D_600D};
    tbl[5] = '{2'b01, 32'h0000_0020, 32'h0BAD_F00D, 2, -1, 32'h0,         4, 32'h0};
    tbl[6] = '{2'b11, 32'h0000_0033, 32'h1111_1111, 0,  1, 32'hCAFE_F00D, 3, 32'hCAFE_F00D};
    tbl[7] = '{2'b10, 32'h0000_0007, 32'h0,         1,  5, 32'h7777_7777, 7, 32'hFFFF_FFFF};

    rst_n             = 1'b0;
    bus.req_valid     = 1'b0;
    bus.req_type      = LOAD;
    bus.req_address   = '0;
    bus.word_to_store = '0;
    bus.mem_ready     = 1'b0;
    bus.mem_rdata     = '0;
    bus.mem_rvalid    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    outputs_zero("reset_outputs");
    rst_n = 1'b1;

    idle_ok = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.mem_valid || bus.req_fulfilled || bus.mem_we || bus.timeout_error ||
          bus.mem_addr != 0 || bus.mem_wdata != 0 || bus.fetched_word != 0) idle_ok = 1'b0;
    end
    chk("idle_quiet", 32'(idle_ok), 32'h1);
    chk("idle_state", 32'(dbg_state), 32'(IDLE));

    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i], $sformatf("vec%0d", i));
      bus.req_valid = 1'b0;
      @(posedge clk); #1;
    end

    // Back-to-back with req_valid held across the switch
    rv_v = '{2'b00, 32'h10, 32'h0, 1, 1, 32'h5555_AAAA, 0, 32'h0};
    run_txn(model(rv_v), "b2b_load");
    rv_v = '{2'b01, 32'h20, 32'h3C3C_3C3C, 0, -1, 32'h0, 0, 32'h0};
    run_txn(model(rv_v), "b2b_store");
    bus.req_valid = 1'b0;
    idle_ok = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.mem_valid || bus.req_fulfilled) idle_ok = 1'b0;
    end
    chk("b2b_no_duplicate", 32'(idle_ok), 32'h1);

    // Reset while waiting for read data
    bus.req_valid   = 1'b1;
    bus.req_type    = LOAD;
    bus.req_address = 32'h200;
    @(posedge clk); #1;
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    chk("rst_pre_state", 32'(dbg_state), 32'(WAIT));
    #2 rst_n = 1'b0;
    #1;
    outputs_zero("rst_async_clear");
    exp_to = 1'b0;
    bus.req_valid = 1'b0;
    idle_ok = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.req_fulfilled || bus.mem_valid) idle_ok = 1'b0;
    end
    chk("rst_no_fulfill", 32'(idle_ok), 32'h1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rv_v = '{2'b00, 32'h204, 32'h0, 0, 2, 32'hFEED_FACE, 0, 32'h0};
    run_txn(model(rv_v), "post_rst_load");
    bus.req_valid = 1'b0;
    @(posedge clk); #1;

    // Randomized transactions against the model
    for (int i = 0; i < 24; i++) begin
      rv_v.typ   = 2'($urandom_range(0, 3));
      rv_v.addr  = $urandom;
      rv_v.wdata = $urandom;
      rv_v.rdy   = $urandom_range(0, 5);
      rv_v.rv    = $urandom_range(0, 7);
      if (rv_v.rv == 7) rv_v.rv = -1;
      rv_v.rdata = $urandom;
      run_txn(model(rv_v), $sformatf("rand%0d", i));
      if ($urandom_range(0, 1) == 1) begin
        bus.req_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    bus.req_valid = 1'b0;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/l2_mem_responder.md
Name: l2_mem_responder

Overview:
- Responder end of the L1-to-L2 word request interface; its requester is the cache request arbiter's L2-side port.
- Accepts one word request at a time: address, memory_operation_e type, valid, and store data.
- Executes each request against a ready/valid backing-memory port, then returns fetched_word with a one-cycle req_fulfilled pulse.
- Includes a response timeout so a hung memory cannot deadlock the L1 caches.

Parameters:
- XLEN, 32, address and data width.
- TIMEOUT_CYCLES, 64, maximum cycles spent waiting for mem_rvalid on a load. Must be ≥1.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- req_address  input  XLEN  requested byte address.
- req_type  input  memory_operation_e  LOAD or STORE, from xentry_pkg.
- req_valid  input  1  request present. Held stable until req_fulfilled.
- word_to_store  input  XLEN  store data. Valid when req_type is STORE.
- fetched_word  output  XLEN  load data. Meaningful during the req_fulfilled cycle.
- req_fulfilled  output  1  one-cycle completion pulse.
- mem_addr  output  XLEN  word-aligned address, {addr[XLEN-1:2],2'b00}.
- mem_we  output  1  1 = write, 0 = read.
- mem_wdata  output  XLEN  write data.
- mem_valid  output  1  memory command valid.
- mem_ready  input  1  memory accepts the command this cycle.
- mem_rdata  input  XLEN  read data.
- mem_rvalid  input  1  read data valid, one-cycle pulse.
- timeout_error  output  1  sticky; set on any load timeout.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - req_fulfilled=0, mem_valid=0, mem_we=0.
  - mem_addr=0, mem_wdata=0, fetched_word=0.
  - timeout_error=0, timeout counter=0.
  - A reset mid-transaction abandons it. No fulfill is issued.
- States: IDLE, ISSUE, WAIT, RESPOND.
- IDLE:
  - If req_valid=1, capture address, type and store data into internal registers, then go to ISSUE.
  - Inputs are not re-sampled until the next IDLE.
- ISSUE:
  - mem_valid=1. mem_addr, mem_we and mem_wdata come from the captured registers and are held stable until mem_ready.
  - mem_we=1 and mem_wdata=captured data for STORE; mem_we=0 and mem_wdata=0 otherwise.
  - On mem_ready=1 with a STORE: go to RESPOND.
  - On mem_ready=1 with a LOAD and mem_rvalid=1 in the same cycle: capture mem_rdata, go to RESPOND.
  - On mem_ready=1 with a LOAD otherwise: clear the counter, go to WAIT.
  - No timeout applies in ISSUE.
- WAIT:
  - mem_valid=0. The counter increments each cycle.
  - On mem_rvalid=1: capture mem_rdata, go to RESPOND. mem_rvalid wins over a simultaneous counter expiry.
  - Else, if counter == TIMEOUT_CYCLES-1: fetched data is all-ones, set timeout_error, go to RESPOND.
- RESPOND:
  - req_fulfilled=1 for exactly this cycle.
  - fetched_word = captured load data, or 0 for STORE.
  - Next state is always IDLE.
- Request handshake:
  - The earliest new request is sampled in the IDLE cycle after RESPOND. A request still valid there is treated as new.
  - The requester deasserts or changes req_valid in the cycle after the pulse.
- Latency (req_valid asserted at IDLE cycle T, mem_ready at first ISSUE cycle):
  - STORE: fulfilled at T+2.
  - LOAD with same-cycle rvalid: fulfilled at T+2.
  - LOAD with rvalid k cycles after acceptance (k≥1): fulfilled at T+2+k.
  - Minimum turnaround between back-to-back requests: 3 cycles.
- fetched_word:
  - Registered, and holds its last value outside RESPOND.
  - Zero is driven in RESPOND for STOREs.
- mem_rvalid outside ISSUE and WAIT is ignored.
- A late rvalid after a timeout is a memory-side protocol violation and is not filtered.
- Any req_type other than LOAD and STORE is treated as LOAD.

Test Plan:
- Reset then idle, req_valid=0 for 10 cycles -> all outputs 0, mem_valid never asserts.
- STORE addr=0x0000_1006, data=0xDEAD_BEEF, mem_ready=1 immediately -> mem_addr=0x0000_1004, mem_we=1, mem_wdata=0xDEAD_BEEF for one cycle; req_fulfilled at T+2 with fetched_word=0.
- LOAD addr=0x40, mem_ready delayed 3 cycles, mem_rvalid 2 cycles after acceptance with rdata=0x1234_5678:
  - mem_valid stays high 4 cycles with address stable;
  - req_fulfilled once with fetched_word=0x1234_5678.
- LOAD with TIMEOUT_CYCLES=4, mem_rvalid never asserted -> fulfill after 4 WAIT cycles, fetched_word=0xFFFF_FFFF, timeout_error=1 stays set through later successful requests.
- Back-to-back: LOAD 0x10 then STORE 0x20, req_valid held high across the switch -> two distinct fulfills, second memory command uses 0x20 with mem_we=1, no duplicate command.
- Assert reset in WAIT -> outputs clear immediately, no req_fulfilled; after release, a new LOAD completes normally.
